// File: rtl/fdiv_pkg.sv
// Shared types and float-format constants for the divider and its arbiter.
package fdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } fdiv_arb_state_t;

  localparam int EXP_LEN_32 = 8;
  localparam int EXP_LEN_64 = 11;
  localparam int MAN_32     = 22;
  localparam int MAN_64     = 51;
  localparam int BIAS_32    = 127;
  localparam int BIAS_64    = 1023;

  // Field geometry for a given float width (anything but 64 is treated as 32).
  function automatic int exp_len(int n);
    return (n == 64) ? EXP_LEN_64 : EXP_LEN_32;
  endfunction

  function automatic int man_msb(int n);
    return (n == 64) ? MAN_64 : MAN_32;
  endfunction

  function automatic int bias(int n);
    return (n == 64) ? BIAS_64 : BIAS_32;
  endfunction

endpackage

// File: rtl/fdiv_arbiter_if.sv
// Requester/response bundle between issue logic and the divider arbiter.
interface fdiv_arbiter_if #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][N-1:0]  req_a;
  logic [NREQ-1:0][N-1:0]  req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [N-1:0]            rsp_data;
  logic                    busy;
  logic [15:0]             done_cnt;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy, done_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy, done_cnt
  );
endinterface

// File: rtl/fdiv.sv
// Combinational IEEE-format divider. Quotient is truncated (round toward
// zero); subnormal inputs and results flush to zero; NaN/Inf inputs give a
// quiet NaN, divide-by-zero gives a signed infinity.
module fdiv
  import fdiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] out
);

  localparam int EL = exp_len(N);
  localparam int MW = man_msb(N) + 1;   // stored fraction bits
  localparam int SW = MW + 1;           // significand incl. hidden one
  localparam logic [EL-1:0]   EMAX = '1;
  localparam logic [EL+1:0]   BI_V = (EL+2)'(bias(N));

  logic              sa, sb, sq;
  logic [EL-1:0]     ea, eb;
  logic [MW-1:0]     fa, fb, frac;
  logic [2*SW-1:0]   num, den, quo;
  logic [EL+1:0]     e_res;
  logic              under, over;
  logic              unused_quo_hi;

  // Significand divide, normalise by one bit, then special-case overrides.
  always_comb begin
    sa = a[N-1];
    sb = b[N-1];
    sq = sa ^ sb;
    ea = a[N-2:MW];
    eb = b[N-2:MW];
    fa = a[MW-1:0];
    fb = b[MW-1:0];

    num = {1'b1, fa, {SW{1'b0}}};
    den = {{SW{1'b0}}, 1'b1, fb};
    quo = num / den;
    unused_quo_hi = |quo[2*SW-1:SW+1];

    e_res = {2'b00, ea} - {2'b00, eb} + BI_V;
    if (quo[SW]) begin
      frac = quo[SW-1:1];
    end else begin
      frac  = quo[SW-2:0];
      e_res = e_res - (EL+2)'(1);
    end

    under = e_res[EL+1] || (e_res == '0);
    over  = !e_res[EL+1] && (e_res[EL:0] >= {1'b0, EMAX});

    out = {sq, e_res[EL-1:0], frac};
    if (ea == EMAX || eb == EMAX || (ea == '0 && eb == '0)) begin
      out = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};
    end else if (eb == '0) begin
      out = {sq, EMAX, {MW{1'b0}}};
    end else if (ea == '0) begin
      out = {sq, {(N-1){1'b0}}};
    end else if (over) begin
      out = {sq, EMAX, {MW{1'b0}}};
    end else if (under) begin
      out = {sq, {(N-1){1'b0}}};
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_pick
  import fdiv_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant_oh,
  output logic [IDW-1:0]  grant_id,
  output logic            any
);

  logic found;

  // Scan NREQ positions starting at ptr; the first hit wins.
  always_comb begin
    grant_oh = '0;
    grant_id = '0;
    found    = 1'b0;
    any      = |req;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_id      = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fdiv_arbiter.sv
// Round-robin front end sharing one fdiv among NREQ requesters, with the
// divider sandwiched between the operand and result registers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for any req_valid; grants and captures operands
// EXEC    | op_a/op_b feed fdiv; quotient captured into res_q
// RESP    | rsp_valid high until rsp_ready; then pointer moves past op_id
module fdiv_arbiter
  import fdiv_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic           clk,
  input logic           rst,
  fdiv_arbiter_if.slave bus
);

  fdiv_arb_state_t state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  op_id_q, op_id_d;
  logic [N-1:0]    op_a_q, op_a_d;
  logic [N-1:0]    op_b_q, op_b_d;
  logic [N-1:0]    res_q, res_d;
  logic [15:0]     done_cnt_q, done_cnt_d;

  logic [NREQ-1:0] grant_oh;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;
  logic [N-1:0]    fdiv_out;
  logic [NREQ-1:0] req_ready;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req      (bus.req_valid),
    .ptr      (rr_ptr_q),
    .grant_oh (grant_oh),
    .grant_id (grant_id),
    .any      (grant_any)
  );

  fdiv #(.N(N)) u_fdiv (
    .a   (op_a_q),
    .b   (op_b_q),
    .out (fdiv_out)
  );

  // Next-state, operand capture and the combinational grant.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_id_d    = op_id_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    res_d      = res_q;
    done_cnt_d = done_cnt_q;
    req_ready  = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          req_ready = grant_oh;
          op_a_d    = bus.req_a[grant_id];
          op_b_d    = bus.req_b[grant_id];
          op_id_d   = grant_id;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = fdiv_out;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d    = ST_IDLE;
          rr_ptr_d   = (op_id_q == IDW'(NREQ-1)) ? '0 : op_id_q + IDW'(1);
          done_cnt_d = done_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Nothing may be accepted while reset is asserted.
    if (rst) req_ready = '0;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      op_id_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_q      <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_id_q    <= op_id_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      res_q      <= res_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_id    = op_id_q;
  assign bus.rsp_data  = res_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_fdiv_arbiter.sv
// Randomised and directed bench for fdiv_arbiter against a transaction model.
module tb_fdiv_arbiter;

  localparam int N  = 32;
  localparam int NA = 4;
  localparam int NB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  fdiv_arbiter_if #(.N(N), .NREQ(NA)) bus_a ();
  fdiv_arbiter_if #(.N(N), .NREQ(NB)) bus_b ();

  fdiv_arbiter #(.N(N), .NREQ(NA)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  fdiv_arbiter #(.N(N), .NREQ(NB)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic real mag(input logic [31:0] x);
    real r;
    int  e;
    r = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return r;
  endfunction

  // Truncated single-precision quotient for normal operands in a safe range.
  function automatic logic [31:0] ref_fdiv(input logic [31:0] a, input logic [31:0] b);
    real q;
    int  e;
    logic [22:0] man;
    logic [7:0]  be;
    q = mag(a) / mag(b);
    e = 0;
    while (q >= 2.0) begin q = q / 2.0; e++; end
    while (q < 1.0)  begin q = q * 2.0; e--; end
    man = 23'($rtoi((q - 1.0) * 8388608.0));
    be  = 8'(e + 127);
    return {a[31] ^ b[31], be, man};
  endfunction

  function automatic logic [31:0] rand_f();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  function automatic int pick(input logic [7:0] v, input int ptr, input int n);
    for (int k = 0; k < n; k++) if (v[(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  // ---------------- model of instance A ----------------
  logic [NA-1:0] s_rdy;
  logic          s_rv, s_busy;
  logic [1:0]    s_id;
  logic [31:0]   s_data;
  logic [15:0]   s_cnt;

  bit          m_inflight;
  int          m_acc, m_id, m_ptr;
  logic [31:0] m_data;
  logic [15:0] m_cnt;
  int          cyc;
  int          acc_id;

  // Called just after a falling edge with inputs already driven; checks the
  // cycle, advances the model and returns at the next falling edge.
  task automatic step_a();
    logic [NA-1:0] exp_rdy;
    bit            exp_rv;
    int            g;
    #1;
    s_rdy  = bus_a.req_ready;
    s_rv   = bus_a.rsp_valid;
    s_id   = bus_a.rsp_id;
    s_data = bus_a.rsp_data;
    s_busy = bus_a.busy;
    s_cnt  = bus_a.done_cnt;
    acc_id = -1;
    if (rst_a) begin
      chk("ready_in_reset", 64'(s_rdy), 64'(0));
      m_inflight = 0;
      m_ptr      = 0;
      m_cnt      = '0;
    end else begin
      exp_rdy = '0;
      g = -1;
      if (!m_inflight && |bus_a.req_valid) begin
        g = pick(8'(bus_a.req_valid), m_ptr, NA);
        exp_rdy[g] = 1'b1;
      end
      exp_rv = m_inflight && (cyc >= m_acc + 2);
      chk("req_ready", 64'(s_rdy), 64'(exp_rdy));
      chk("rsp_valid", 64'(s_rv), 64'(exp_rv));
      chk("busy", 64'(s_busy), 64'(m_inflight));
      chk("done_cnt", 64'(s_cnt), 64'(m_cnt));
      if (exp_rv) begin
        chk("rsp_id", 64'(s_id), 64'(m_id));
        chk("rsp_data", 64'(s_data), 64'(m_data));
      end
      if (g >= 0) begin
        m_inflight = 1;
        m_acc      = cyc;
        m_id       = g;
        m_data     = ref_fdiv(bus_a.req_a[g], bus_a.req_b[g]);
        acc_id     = g;
      end
      if (exp_rv && bus_a.rsp_ready) begin
        m_inflight = 0;
        m_ptr      = (m_id + 1) % NA;
        m_cnt      = m_cnt + 16'd1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    step_a();
    step_a();
    rst_a = 1'b0;
  endtask

  // ---------------- instance B helper ----------------
  task automatic wait_acc_b(output int id);
    id = -1;
    for (int t = 0; t < 20 && id < 0; t++) begin
      #1;
      for (int i = 0; i < NB; i++) if (bus_b.req_ready[i]) id = i;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ids[$];
    int cycs[$];
    logic [31:0] exp_bp, a2, b2, exp_b;
    int id, got;

    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.req_valid = '0; bus_a.req_a = '0; bus_a.req_b = '0; bus_a.rsp_ready = 1'b0;
    bus_b.req_valid = '0; bus_b.req_a = '0; bus_b.req_b = '0; bus_b.rsp_ready = 1'b0;
    m_inflight = 0; m_ptr = 0; m_cnt = '0; cyc = 0; m_acc = 0; m_id = 0; m_data = '0;
    @(negedge clk);

    // Reset values
    reset_a();
    step_a();
    chk("rst_req_ready", 64'(s_rdy), 64'(0));
    chk("rst_rsp_valid", 64'(s_rv), 64'(0));
    chk("rst_rsp_id", 64'(s_id), 64'(0));
    chk("rst_rsp_data", 64'(s_data), 64'(0));
    chk("rst_busy", 64'(s_busy), 64'(0));
    chk("rst_done_cnt", 64'(s_cnt), 64'(0));

    // Single request 6.0 / 2.0
    bus_a.req_valid = 4'b0001;
    bus_a.req_a[0] = 32'h40C00000;
    bus_a.req_b[0] = 32'h40000000;
    bus_a.rsp_ready = 1'b1;
    step_a();
    chk("single_accept", 64'(acc_id), 64'(0));
    bus_a.req_valid = '0;
    step_a();
    chk("single_exec_no_rsp", 64'(s_rv), 64'(0));
    step_a();
    chk("single_rsp_valid_t2", 64'(s_rv), 64'(1));
    chk("single_rsp_data", 64'(s_data), 64'h40400000);
    chk("single_rsp_id", 64'(s_id), 64'(0));
    step_a();
    chk("single_done_cnt", 64'(s_cnt), 64'(1));

    // Fairness with all requesters active
    reset_a();
    for (int i = 0; i < NA; i++) begin
      bus_a.req_a[i] = rand_f();
      bus_a.req_b[i] = rand_f();
    end
    bus_a.req_valid = 4'b1111;
    bus_a.rsp_ready = 1'b1;
    for (int t = 0; t < 15; t++) begin
      step_a();
      if (acc_id >= 0) begin
        ids.push_back(acc_id);
        cycs.push_back(cyc);
        bus_a.req_a[acc_id] = rand_f();
        bus_a.req_b[acc_id] = rand_f();
      end
    end
    chk("fair_accept_count", 64'(ids.size()), 64'(5));
    for (int k = 0; k < ids.size() && k < 5; k++) begin
      chk("fair_order", 64'(ids[k]), 64'(k % NA));
      if (k > 0) chk("fair_spacing", 64'(cycs[k] - cycs[k-1]), 64'(3));
    end
    bus_a.req_valid = '0;
    step_a();
    step_a();

    // Backpressure: rsp_ready low for five RESP cycles
    bus_a.req_valid = 4'b0010;
    bus_a.req_a[1] = rand_f();
    bus_a.req_b[1] = rand_f();
    exp_bp = ref_fdiv(bus_a.req_a[1], bus_a.req_b[1]);
    bus_a.rsp_ready = 1'b0;
    step_a();
    chk("bp_accept", 64'(acc_id), 64'(1));
    bus_a.req_valid = 4'b1111;
    step_a();
    for (int t = 0; t < 5; t++) begin
      step_a();
      chk("bp_rsp_valid", 64'(s_rv), 64'(1));
      chk("bp_rsp_data", 64'(s_data), 64'(exp_bp));
      chk("bp_rsp_id", 64'(s_id), 64'(1));
      chk("bp_req_ready", 64'(s_rdy), 64'(0));
    end
    bus_a.rsp_ready = 1'b1;
    step_a();
    step_a();
    chk("bp_idle_busy", 64'(s_busy), 64'(0));
    chk("bp_next_grant", 64'(acc_id), 64'(2));

    // Reset while the granted operation is in EXEC
    rst_a = 1'b1;
    step_a();
    rst_a = 1'b0;
    bus_a.req_valid = '0;
    step_a();
    chk("rstmid_rsp_valid", 64'(s_rv), 64'(0));
    chk("rstmid_busy", 64'(s_busy), 64'(0));
    for (int t = 0; t < 4; t++) begin
      step_a();
      chk("rstmid_no_rsp", 64'(s_rv), 64'(0));
    end
    bus_a.req_valid = 4'b1111;
    step_a();
    chk("rstmid_ptr_zero", 64'(acc_id), 64'(0));

    // done_cnt wrap
    bus_a.req_valid = '0;
    bus_a.rsp_ready = 1'b0;
    step_a();
    step_a();
    force dut_a.done_cnt_q = 16'hFFFF;
    #1;
    release dut_a.done_cnt_q;
    m_cnt = 16'hFFFF;
    bus_a.rsp_ready = 1'b1;
    step_a();
    chk("wrap_handshake", 64'(s_rv), 64'(1));
    step_a();
    chk("wrap_done_cnt", 64'(s_cnt), 64'(0));

    // Randomised traffic
    s_rdy = '0;
    for (int t = 0; t < 500; t++) begin
      bus_a.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NA; i++) begin
        if (bus_a.req_valid[i] && !s_rdy[i]) begin
          if ($urandom_range(0, 19) == 0) bus_a.req_valid[i] = 1'b0;
        end else begin
          bus_a.req_valid[i] = 1'($urandom_range(0, 1));
          bus_a.req_a[i] = rand_f();
          bus_a.req_b[i] = rand_f();
        end
      end
      step_a();
    end
    bus_a.req_valid = '0;
    bus_a.rsp_ready = 1'b1;
    for (int t = 0; t < 4; t++) step_a();

    // Pointer wrap on the three-requester instance
    rst_b = 1'b0;
    a2 = rand_f();
    b2 = rand_f();
    bus_b.req_a[2] = a2;
    bus_b.req_b[2] = b2;
    bus_b.req_valid = 3'b100;
    bus_b.rsp_ready = 1'b1;
    wait_acc_b(id);
    chk("b_first_grant", 64'(id), 64'(2));
    exp_b = ref_fdiv(a2, b2);
    bus_b.req_a[2] = rand_f();
    bus_b.req_b[2] = rand_f();
    bus_b.req_a[0] = rand_f();
    bus_b.req_b[0] = rand_f();
    bus_b.req_valid = 3'b101;
    got = 0;
    for (int t = 0; t < 10 && got == 0; t++) begin
      #1;
      if (bus_b.rsp_valid) begin
        got = 1;
        chk("b_rsp_id", 64'(bus_b.rsp_id), 64'(2));
        chk("b_rsp_data", 64'(bus_b.rsp_data), 64'(exp_b));
      end
      @(negedge clk);
    end
    chk("b_rsp_seen", 64'(got), 64'(1));
    wait_acc_b(id);
    chk("b_wrap_grant", 64'(id), 64'(0));
    wait_acc_b(id);
    chk("b_after_wrap_grant", 64'(id), 64'(2));
    bus_b.req_valid = '0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fdiv_arbiter.md
# fdiv_arbiter

Round-robin scheduler that shares one combinational `fdiv` instance among `NREQ` requesters. It accepts one division request at a time over per-requester valid/ready handshakes and registers the operands. It registers the `fdiv` result and returns it, tagged with the requester id, over a single response channel with backpressure. It sits between the issue logic and the single floating-point divider, so the divider's long combinational path stays between two register stages.

## Interface
Parameters:
- `N`, 32: float width, 32 or 64; passed to `fdiv`.
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`: requester-id width (derived).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, `NREQ`: request present, one bit per requester.
- `req_ready`, out, `NREQ`: request accepted this cycle, one-hot or zero.
- `req_a`, in, `NREQ`×`N`: dividend per requester.
- `req_b`, in, `NREQ`×`N`: divisor per requester.
- `rsp_valid`, out, 1: result available.
- `rsp_ready`, in, 1: consumer takes the result.
- `rsp_id`, out, `IDW`: requester that issued the result.
- `rsp_data`, out, `N`: quotient, bit-equal to `fdiv(a, b)`.
- `busy`, out, 1: high in `EXEC` or `RESP`.
- `done_cnt`, out, 16: completed-response counter; wraps 0xFFFF→0.

## Operation
- FSM states: `IDLE`, `EXEC`, `RESP`.
- **IDLE**:
  - If any `req_valid` is high, grant the first set bit searching upward from `rr_ptr`, modulo `NREQ`.
  - Drive `req_ready[grant]=1` combinationally in the same cycle.
  - Capture `req_a`/`req_b`/grant into `op_a`, `op_b` and `op_id`, then go to `EXEC`.
  - With no `req_valid`, stay in `IDLE` with `req_ready=0`.
- **EXEC**: `op_a`/`op_b` drive `fdiv`. Register its `out` into `res_q` and go to `RESP`. `req_ready=0`.
- **RESP**:
  - `rsp_valid=1`, `rsp_data=res_q`, `rsp_id=op_id`.
  - On `rsp_ready`: go to `IDLE`, set `rr_ptr = op_id+1` (mod `NREQ`), increment `done_cnt`.
  - Without `rsp_ready`: hold all outputs stable.
- `req_ready` is 0 in every state except `IDLE`, so there is never a second request in flight.
- Requesters must hold `req_a`/`req_b` stable while `req_valid` is high and not yet accepted. Deasserting `req_valid` before acceptance is legal and simply drops that request from arbitration.
- Sign, special-value and exponent handling belong entirely to `fdiv`. The arbiter does not inspect operands.

## Timing
- Reset (`rst` high at a clock edge): state=`IDLE`, `rr_ptr`=0, `op_*`=0, `res_q`=0, `done_cnt`=0. Outputs: `req_ready`=0 during reset, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0.
- Reset mid-operation discards the in-flight operation with no response. `req_ready` is forced to 0 while `rst` is high.
- Latency: accept at edge t (`req_ready` high in cycle t) → `rsp_valid` high in cycle t+2.
- Throughput: one operation per 3 cycles with `rsp_ready` tied high. The next accept happens in the cycle after the `RESP` handshake.
- Fairness: a requester holding `req_valid` is granted within `NREQ` completed operations.
- `NREQ` not a power of two: `rr_ptr` wraps from `NREQ-1` to 0, never reaching unused codes.
- `done_cnt` increments only on the `rsp_valid & rsp_ready` edge.

## Structure
- Shared package `fdiv_pkg`:
  - FSM state enum `fdiv_arb_state_t`.
  - Width localparams per `N`: EXP_LEN 8/11, MAN 22/51.
  - `BIAS` constant.
- Sub-module `rr_pick #(NREQ)`: combinational round-robin picker. Inputs `req`, `ptr`; outputs `grant_oh`, `grant_id`, `any`.
- Top instantiates `rr_pick` and exactly one `fdiv #(N)`.

## Test plan
- **Single request**: requester 0 sends a=0x40C00000 (6.0), b=0x40000000 (2.0) → accept cycle t, `rsp_valid` at t+2, `rsp_data`=0x40400000, `rsp_id`=0, `done_cnt`=1.
- **Fairness**: all four `req_valid` held high, `rsp_ready`=1 → grant order 0,1,2,3,0 with accepts every 3 cycles. Each `rsp_data` matches the reference `fdiv` model for that requester's operands.
- **Backpressure**: `rsp_ready`=0 for 5 cycles in `RESP` → `rsp_valid`, `rsp_data` and `rsp_id` stable and `req_ready`=0 throughout. Release → handshake, `IDLE` next cycle.
- **Reset mid-operation**: `rst` pulsed in `EXEC` → next cycle `rsp_valid`=0, `busy`=0, `rr_ptr`=0, and no response for the dropped request.
- **Pointer wrap with NREQ=3**: only requester 2 active, then requesters 0 and 2 → after serving 2, requester 0 is granted before 2.
- **Counter wrap**: preload 65535 completions (force or loop) → one more handshake gives `done_cnt`=0.
